// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if
// Stream bundle between the issue stage (master) and the dispatcher (slave).
//   in_valid/in_ready/in_data/in_sel : one tagged input word per cycle
//   out_valid/out_ready/out_data     : NCH independent output channels,
//                                      channel k in out_data[k*WIDTH +: WIDTH]
//   drop_err                         : pulse when an out-of-range word was dropped
interface demux_dispatch_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           in_sel;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic                 drop_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_err
  );
endinterface

// File: rtl/demux_dispatch.sv
// demux_dispatch
// One-to-NCH stream dispatcher. Each accepted word is routed by in_sel into a
// one-entry register of its channel; channels drain independently. A flush
// empties every slot (data registers are kept). Words whose in_sel has no
// channel (only possible when NCH < 4) are consumed and reported on drop_err.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   flush : synchronous clear of all channel slots
//   bus   : demux_dispatch_if.slave (input stream, NCH output streams, drop_err)
//   perf_cnt  [NCH*32] : per-channel delivered-word counters (optional)
//   perf_drop [16]     : saturating dropped-word counter (optional)
//
// Optional feature: define DEMUX_DISPATCH_PERF_EN to add perf_cnt/perf_drop.
module demux_dispatch #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  demux_dispatch_if.slave    bus
`ifdef DEMUX_DISPATCH_PERF_EN
  ,
  output logic [NCH*32-1:0]  perf_cnt,
  output logic [15:0]        perf_drop
`endif
);

  generate
    if (NCH < 2 || NCH > 4) begin : g_bad_nch
      $error("demux_dispatch: NCH must be in 2..4");
    end
  endgenerate

  logic [NCH-1:0] hit_vec;
  logic [NCH-1:0] full_vec;
  logic           sel_in_range;
  logic           sel_full;
  logic           sel_ordy;
  logic           in_ready_c;
  logic           take;
  logic           drop_q, drop_d;

  // in_ready looks only at the addressed slot; a full slot that is being
  // drained this cycle can still take a word, giving 1 word/cycle throughput.
  assign sel_in_range = (int'(bus.in_sel) < NCH);
  assign sel_full     = |(hit_vec & full_vec);
  assign sel_ordy     = |(hit_vec & bus.out_ready);
  assign in_ready_c   = !flush & (!sel_in_range | !sel_full | sel_ordy);
  assign bus.in_ready = in_ready_c;
  assign take         = bus.in_valid & in_ready_c;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic             full_q, full_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             accept;
      logic             drain;

      assign hit_vec[gi]  = (bus.in_sel == 2'(gi));
      assign accept       = take & hit_vec[gi];
      assign drain        = full_q & bus.out_ready[gi];
      // accept already implies !flush, so flush wins over everything else.
      assign full_d       = !flush & (accept | (full_q & !drain));
      assign data_d       = accept ? bus.in_data : data_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else begin
          full_q <= full_d;
          data_q <= data_d;
        end
      end

      assign full_vec[gi]                      = full_q;
      assign bus.out_valid[gi]                 = full_q;
      assign bus.out_data[gi*WIDTH +: WIDTH]   = data_q;

`ifdef DEMUX_DISPATCH_PERF_EN
      // Counts deliveries, including those in a flush cycle; wraps naturally.
      logic [31:0] cnt_q, cnt_d;
      assign cnt_d = cnt_q + 32'(drain);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
      assign perf_cnt[gi*32 +: 32] = cnt_q;
`endif
    end
  endgenerate

  // A dropped word is consumed like any other, so it needs in_ready, which
  // is already low during flush.
  assign drop_d = take & !sel_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  assign bus.drop_err = drop_q;

`ifdef DEMUX_DISPATCH_PERF_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  // Counts the registered pulses, saturating at all-ones.
  assign drop_cnt_d = (drop_q && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end
  assign perf_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_dispatch.sv
// Scoreboard bench: two dispatcher instances (NCH=4 and NCH=3) share one
// stimulus stream. Each instance has its own reference model built from
// per-channel queues of words still owed to the consumer.
module tb_demux_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_flush = 1'b0;
  logic        s_in_valid = 1'b0;
  logic [1:0]  s_in_sel = '0;
  logic [31:0] s_in_data = '0;
  logic [3:0]  s_out_ready = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s nch%0d t=%0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int NCH_G = (gi == 0) ? 4 : 3;

      demux_dispatch_if #(.WIDTH(32), .NCH(NCH_G)) bus ();
      assign bus.in_valid  = s_in_valid;
      assign bus.in_sel    = s_in_sel;
      assign bus.in_data   = s_in_data;
      assign bus.out_ready = s_out_ready[NCH_G-1:0];

`ifdef DEMUX_DISPATCH_PERF_EN
      logic [NCH_G*32-1:0] perf_cnt;
      logic [15:0]         perf_drop;
`endif

      demux_dispatch #(.WIDTH(32), .NCH(NCH_G)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (s_flush),
        .bus   (bus.slave)
`ifdef DEMUX_DISPATCH_PERF_EN
        ,
        .perf_cnt  (perf_cnt),
        .perf_drop (perf_drop)
`endif
      );

      // Reference model state
      logic [31:0] exp_q [4][$];   // words owed to each channel's consumer
      logic [31:0] last_data [4];  // what each channel's data output should show
      logic        exp_drop;
      int unsigned deliv [4];
      int unsigned drops;

      always @(negedge clk) begin
        logic exp_ready;
        logic in_range;
        if (rst) begin
          for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_data[k] = '0;
            deliv[k] = 0;
          end
          exp_drop = 1'b0;
          drops = 0;
        end else begin
          in_range = (int'(s_in_sel) < NCH_G);
          if (s_flush)        exp_ready = 1'b0;
          else if (!in_range) exp_ready = 1'b1;
          else                exp_ready = (exp_q[s_in_sel].size() == 0) || s_out_ready[s_in_sel];

          for (int k = 0; k < NCH_G; k++) begin
            chk("out_valid", NCH_G, 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
            chk("out_data", NCH_G, bus.out_data[k*32 +: 32], last_data[k]);
`ifdef DEMUX_DISPATCH_PERF_EN
            chk("perf_cnt", NCH_G, perf_cnt[k*32 +: 32], deliv[k]);
`endif
          end
          chk("drop_err", NCH_G, 32'(bus.drop_err), 32'(exp_drop));
          chk("in_ready", NCH_G, 32'(bus.in_ready), 32'(exp_ready));
`ifdef DEMUX_DISPATCH_PERF_EN
          chk("perf_drop", NCH_G, 32'(perf_drop), drops);
          if (exp_drop && drops != 32'hFFFF) drops++;
`endif

          // Output handshakes: pop the owed word and compare it (flush cycle included).
          for (int k = 0; k < NCH_G; k++) begin
            if (exp_q[k].size() != 0 && s_out_ready[k]) begin
              chk("deliver", NCH_G, bus.out_data[k*32 +: 32], exp_q[k][0]);
              void'(exp_q[k].pop_front());
              deliv[k]++;
            end
          end

          exp_drop = 1'b0;
          if (s_flush) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
          end else if (s_in_valid && exp_ready) begin
            if (in_range) begin
              exp_q[s_in_sel].push_back(s_in_data);
              last_data[s_in_sel] = s_in_data;
            end else begin
              exp_drop = 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy, input logic fl);
    s_in_valid  = v;
    s_in_sel    = sel;
    s_in_data   = d;
    s_out_ready = ordy;
    s_flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: every in_sel must be ready with no backpressure.
    for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), 32'h0, 4'b0000, 1'b0);

    // Basic route into channel 2, then probe in_ready on channels 2 and 1.
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0);
    drive(1'b0, 2'd2, 32'h0, 4'b0000, 1'b0);
    drive(1'b0, 2'd1, 32'h0, 4'b0000, 1'b0);

    // Mid-cycle asynchronous reset while channel 2 holds a word.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 4, 32'(g_cfg[0].bus.out_valid), 32'h0);
    chk("rst_out_data",  4, 32'(g_cfg[0].bus.out_data != '0), 32'h0);
    chk("rst_drop_err",  4, 32'(g_cfg[0].bus.drop_err), 32'h0);
    chk("rst_out_valid", 3, 32'(g_cfg[1].bus.out_valid), 32'h0);
    chk("rst_out_data",  3, 32'(g_cfg[1].bus.out_data != '0), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back into channel 0 while it drains every cycle.
    for (int i = 1; i <= 4; i++) drive(1'b1, 2'd0, 32'(i), 4'b0001, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // in_sel=3: backpressure hold on NCH=4, a drop on NCH=3.
    drive(1'b1, 2'd3, 32'hA5, 4'b0000, 1'b0);
    repeat (5) drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b1000, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // Consecutive drops on NCH=3 (two accepts into channel 3 on NCH=4).
    drive(1'b1, 2'd3, 32'h11, 4'b1000, 1'b0);
    drive(1'b1, 2'd3, 32'h22, 4'b1000, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b1000, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // Flush with channels 0, 1, 3 full and a pending input word.
    drive(1'b1, 2'd0, 32'h100, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 32'h101, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 32'h103, 4'b0000, 1'b0);
    drive(1'b1, 2'd2, 32'h102, 4'b0000, 1'b1);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // Flush while a channel is being drained: that word counts as delivered.
    drive(1'b1, 2'd1, 32'h201, 4'b0000, 1'b0);
    drive(1'b1, 2'd0, 32'h202, 4'b0010, 1'b1);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            $urandom,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
- One-to-N stream dispatcher: the splitting counterpart of the core's N-to-1 select muxes.
- Accepts one tagged word per cycle on a valid/ready input and routes it by `sel` into a per-channel one-entry output register.
- Sits between the issue stage and the functional-unit input ports (ALU/FPU/LSU/branch).
- A flush (branch mispredict) discards all buffered words.

Parameters:
- WIDTH, 32, data width in bits.
- NCH, 4, number of output channels; legal range 2..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all channel slots.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid=1.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel index.
- out_valid  output  NCH  per-channel slot full.
- out_ready  input  NCH  per-channel consumer ready.
- out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- drop_err  output  1  one-cycle pulse: a word with in_sel >= NCH was consumed and dropped.

Behaviour:
- Reset (async, rst=1):
  - out_valid = 0, out_data = 0, drop_err = 0.
  - All slots empty; counters (if enabled) = 0.
  - Takes effect immediately, independent of clk.
  - Any in-flight word is lost.
- Per-channel slot k: state EMPTY/FULL, tracked by a full[k] flag; out_valid[k] = full[k].
- Transfer:
  - Output handshake on channel k fires when out_valid[k] & out_ready[k].
  - Input handshake fires when in_valid & in_ready.
- in_ready (combinational, no dependence on in_data):
  - flush=1 -> in_ready = 0.
  - in_sel >= NCH -> in_ready = 1 (word is consumed and dropped).
  - Otherwise in_ready = !full[in_sel] | out_ready[in_sel].
  - This allows full throughput of 1 word/cycle into a channel being drained in the same cycle.
  - in_ready may depend on in_sel and out_ready; it must not depend on in_valid.
- Accept into channel k = in_sel:
  - Next cycle full[k] = 1 and out_data[k] = in_data.
  - Latency: exactly 1 cycle from input handshake to out_valid.
- Drain only (output handshake on k, no accept to k): full[k] = 0 next cycle; out_data[k] holds its old value.
- Simultaneous drain and accept on the same channel: full[k] stays 1 and out_data[k] takes the new word.
- Other channels are unaffected by accepts to k; all channels drain independently and in parallel.
- out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- Out-of-range in_sel (possible only when NCH<4):
  - Word consumed, no slot written.
  - drop_err = 1 for the next cycle only.
  - Consecutive drops give consecutive pulses.
- flush=1 (sampled on clk):
  - All full[] cleared next cycle; no accept that cycle; drop_err not raised.
  - Output handshakes occurring in the flush cycle still count as delivered.
  - out_data registers are left unchanged.
- in_valid=0: in_sel and in_data are ignored; no state change except drains.
- Outputs are registered (out_valid, out_data, drop_err); in_ready is combinational.
- NCH outside 2..4 is an elaboration error.

Optional Feature:
- Macro: DEMUX_DISPATCH_PERF_EN.
- Defined:
  - Adds output `perf_cnt` of width NCH*32: one free-running 32-bit counter per channel.
  - A counter increments on each output handshake of its channel and wraps 0xFFFFFFFF -> 0.
  - Counters are cleared by rst only, not by flush.
  - Adds output `perf_drop` of width 16, counting drop_err pulses and saturating at 0xFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, NCH=4:
  - Assert rst mid-cycle -> out_valid=0000 and drop_err=0 immediately.
  - in_ready=1 for every in_sel with out_ready=0000.
- Basic route:
  - in_valid=1, in_sel=2, in_data=0xDEADBEEF, out_ready=0000 -> next cycle out_valid=0100 and out_data[2]=0xDEADBEEF.
  - Then in_sel=2 gives in_ready=0; in_sel=1 gives in_ready=1.
- Back-to-back same channel:
  - out_ready[0]=1 held, in_sel=0, data 1,2,3,4 on 4 consecutive cycles.
  - Required: in_ready=1 throughout, channel 0 emits 1,2,3,4 on consecutive cycles, no bubbles.
- Backpressure hold:
  - Channel 3 full with 0xA5, out_ready[3]=0 for 5 cycles -> out_data[3] stays 0xA5 and out_valid[3] stays 1.
  - Raise out_ready[3] -> out_valid[3]=0 next cycle.
- Flush:
  - Channels 0, 1 and 3 full; flush=1 with in_valid=1 -> in_ready=0 that cycle and out_valid=0000 next cycle.
  - With the feature enabled, perf_cnt is unchanged.
- Drop with NCH=3:
  - in_sel=3, in_valid=1 -> in_ready=1, drop_err=1 for exactly one cycle, out_valid unchanged.
  - With the feature enabled, perf_drop increments by 1.
